// File: rtl/kernel_a_pipe.sv
// Four-stage, lane-parallel kernel_A datapath with valid/ready handshakes on both sides.
// Each lane: l1=a+b, l2=a-b, l3=l1*l2, l4=l3+l1, vout=l4+l1, all wrapping at DATAW bits.
module kernel_a_pipe #(
    parameter int DATAW  = 32,
    parameter int NLANES = 1,
    parameter int CNTW   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NLANES*DATAW-1:0] in_vin0,
    input  logic [NLANES*DATAW-1:0] in_vin1,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NLANES*DATAW-1:0] out_vout,
    output logic [CNTW-1:0]         out_count
);

    logic            v1_reg;
    logic            v2_reg;
    logic            v3_reg;
    logic            v4_reg;
    logic            en;
    logic [CNTW-1:0] count_reg;
    logic [CNTW-1:0] count_next;

    // The whole pipeline advances as one unit; bubbles are kept, not squeezed out.
    assign en        = ~v4_reg | out_ready;
    assign in_ready  = en;
    assign out_valid = v4_reg;
    assign out_count = count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_reg <= 1'b0;
            v2_reg <= 1'b0;
            v3_reg <= 1'b0;
            v4_reg <= 1'b0;
        end else if (en) begin
            v1_reg <= in_valid;
            v2_reg <= v1_reg;
            v3_reg <= v2_reg;
            v4_reg <= v3_reg;
        end
    end

    always_comb begin
        count_next = count_reg;
        if (v4_reg && out_ready) begin
            count_next = count_reg + CNTW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NLANES; gi = gi + 1) begin : g_lane
            logic [DATAW-1:0] a;
            logic [DATAW-1:0] b;
            logic [DATAW-1:0] l1_next;
            logic [DATAW-1:0] l2_next;
            logic [DATAW-1:0] l3_next;
            logic [DATAW-1:0] l4_next;
            logic [DATAW-1:0] vout_next;
            logic [DATAW-1:0] l1_reg;
            logic [DATAW-1:0] l2_reg;
            logic [DATAW-1:0] l3_reg;
            logic [DATAW-1:0] l1_d2_reg;
            logic [DATAW-1:0] l4_reg;
            logic [DATAW-1:0] l1_d3_reg;
            logic [DATAW-1:0] vout_reg;

            assign a = in_vin0[gi*DATAW +: DATAW];
            assign b = in_vin1[gi*DATAW +: DATAW];

            // Only the low DATAW bits of the product are kept.
            always_comb begin
                l1_next   = a + b;
                l2_next   = a - b;
                l3_next   = l1_reg * l2_reg;
                l4_next   = l3_reg + l1_d2_reg;
                vout_next = l4_reg + l1_d3_reg;
            end

            // l1 rides along in l1_d2/l1_d3 so later nodes see the same beat's l1.
            always_ff @(posedge clk) begin
                if (rst) begin
                    l1_reg    <= '0;
                    l2_reg    <= '0;
                    l3_reg    <= '0;
                    l1_d2_reg <= '0;
                    l4_reg    <= '0;
                    l1_d3_reg <= '0;
                    vout_reg  <= '0;
                end else if (en) begin
                    l1_reg    <= l1_next;
                    l2_reg    <= l2_next;
                    l3_reg    <= l3_next;
                    l1_d2_reg <= l1_reg;
                    l4_reg    <= l4_next;
                    l1_d3_reg <= l1_d2_reg;
                    vout_reg  <= vout_next;
                end
            end

            assign out_vout[gi*DATAW +: DATAW] = vout_reg;
        end
    endgenerate

endmodule
